// File: rtl/dmem_rr_arbiter_pkg.sv
// Shared constants and helpers for the round-robin data-memory arbiter.
// No logic of its own; imported by the picker and the top level.
// Index arithmetic uses an explicit wrap so NUM_REQ need not be a power of two.
package dmem_rr_arbiter_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_MASK_W = 4;

    // Default requester count: one port per core in the three-core build.
    localparam int NUM_REQ_DEF = 3;

    // Next index in a ring of n entries, wrapping from n-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dmem_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first asserted request at or after base wins.
// Purely combinational, zero latency.
// No backpressure of its own; a request not picked simply stays pending upstream.
module dmem_rr_arbiter_rr_pick
    import dmem_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   base,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               vld
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] cand;

    // Walk the ring once starting at base; the first set request claims the grant.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        vld  = 1'b0;
        cand = base;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!vld && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                vld       = 1'b1;
            end
            // Explicit wrap so a non-power-of-two ring never visits a phantom index.
            cand = (cand == LAST_IDX) ? '0 : cand + IDX_W'(1);
        end
    end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one combinational-read data-memory port among NUM_REQ harts.
// Grant is combinational; the response (valid + read data) is registered, 1 cycle after grant.
// A requester without a grant stalls with its request held; one access is accepted per cycle.
module dmem_rr_arbiter
    import dmem_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int CNT_W   = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ-1:0]             i_req_wen,
    input  logic [DMEM_ADDR_W*NUM_REQ-1:0] i_req_addr,
    input  logic [DMEM_DATA_W*NUM_REQ-1:0] i_req_wdata,
    input  logic [DMEM_MASK_W*NUM_REQ-1:0] i_req_mask,
    output logic [NUM_REQ-1:0]             o_req_gnt,
    output logic [NUM_REQ-1:0]             o_rsp_valid,
    output logic [DMEM_DATA_W-1:0]         o_rsp_rdata,
    output logic [DMEM_ADDR_W-1:0]         o_mem_addr,
    output logic                           o_mem_ren,
    output logic                           o_mem_wen,
    output logic [DMEM_DATA_W-1:0]         o_mem_wdata,
    output logic [DMEM_MASK_W-1:0]         o_mem_mask,
    input  logic [DMEM_DATA_W-1:0]         i_mem_rdata,
    output logic [CNT_W-1:0]               o_conflict_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Registered state.
    logic [IDX_W-1:0]       ptr_q,       ptr_d;
    logic [NUM_REQ-1:0]     rsp_vld_q,   rsp_vld_d;
    logic [DMEM_DATA_W-1:0] rsp_data_q,  rsp_data_d;
    logic [CNT_W-1:0]       conflict_q,  conflict_d;

    // Picker results.
    logic [NUM_REQ-1:0]     pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_vld;

    // Fields of the winning requester (address bits [1:0] are dropped on the way in).
    logic                   win_wen;
    logic [DMEM_ADDR_W-3:0] win_addr_hi;
    logic [DMEM_DATA_W-1:0] win_wdata;
    logic [DMEM_MASK_W-1:0] win_mask;
    logic                   win_any_lane;
    logic                   win_act;
    logic                   multi_req;

    dmem_rr_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req  (i_req),
        .base (ptr_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .vld  (pick_vld)
    );

    // Select the winning requester's access fields; all zero when nobody wins.
    always_comb begin
        win_wen     = 1'b0;
        win_addr_hi = '0;
        win_wdata   = '0;
        win_mask    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_vld && (pick_idx == IDX_W'(i))) begin
                win_wen     = i_req_wen[i];
                win_addr_hi = i_req_addr[i*DMEM_ADDR_W + 2 +: DMEM_ADDR_W - 2];
                win_wdata   = i_req_wdata[i*DMEM_DATA_W +: DMEM_DATA_W];
                win_mask    = i_req_mask[i*DMEM_MASK_W +: DMEM_MASK_W];
            end
        end
    end

    // Drive grant and the shared memory port; reset blanks everything so no write slips through.
    always_comb begin
        win_any_lane = |win_mask;
        win_act      = pick_vld & ~i_rst;

        o_req_gnt   = win_act ? pick_gnt : '0;
        o_mem_addr  = win_act ? {win_addr_hi, 2'b00} : '0;
        o_mem_wdata = win_act ? win_wdata : '0;
        o_mem_mask  = win_act ? win_mask : '0;
        // Zero-mask accesses are still granted and answered but never touch memory.
        o_mem_ren   = win_act & ~win_wen & win_any_lane;
        o_mem_wen   = win_act &  win_wen & win_any_lane;

        o_rsp_valid    = i_rst ? '0 : rsp_vld_q;
        o_rsp_rdata    = rsp_data_q;
        o_conflict_cnt = conflict_q;
    end

    // Next-state: rotate priority past the winner, capture the response, count contention.
    always_comb begin
        ptr_d      = ptr_q;
        rsp_vld_d  = '0;
        rsp_data_d = rsp_data_q;
        conflict_d = conflict_q;

        if (pick_vld) begin
            ptr_d      = IDX_W'(wrap_inc(32'(pick_idx), NUM_REQ));
            rsp_vld_d  = pick_gnt;
            // Writes and empty-mask reads return zero so stale data never looks like a read.
            rsp_data_d = (~win_wen & win_any_lane) ? i_mem_rdata : '0;
        end

        // Two or more bits set iff clearing the lowest set bit leaves something behind.
        multi_req = |(i_req & (i_req - NUM_REQ'(1)));
        if (multi_req && (conflict_q != {CNT_W{1'b1}})) begin
            conflict_d = conflict_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q      <= '0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
            conflict_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
            conflict_q <= conflict_d;
        end
    end

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Directed bench for dmem_rr_arbiter with a one-entry-deep response scoreboard.
// Expected grants and response data are pushed at grant time and popped a cycle later.
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_dmem_rr_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N-1:0]      req, wen;
    logic [32*N-1:0]   addr, wdata;
    logic [4*N-1:0]    mask;

    logic [N-1:0]      gnt, rsp_vld;
    logic [31:0]       rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic              mem_ren, mem_wen;
    logic [3:0]        mem_mask;
    logic [15:0]       cnt;

    logic [N-1:0]      gnt_s, rsp_vld_s;
    logic [31:0]       rsp_rdata_s, mem_addr_s, mem_wdata_s;
    logic              mem_ren_s, mem_wen_s;
    logic [3:0]        mem_mask_s;
    logic [1:0]        cnt_s;

    dmem_rr_arbiter #(.NUM_REQ(N), .CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_wen(wen),
        .i_req_addr(addr), .i_req_wdata(wdata), .i_req_mask(mask),
        .o_req_gnt(gnt), .o_rsp_valid(rsp_vld), .o_rsp_rdata(rsp_rdata),
        .o_mem_addr(mem_addr), .o_mem_ren(mem_ren), .o_mem_wen(mem_wen),
        .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask), .i_mem_rdata(mem_rdata),
        .o_conflict_cnt(cnt)
    );

    dmem_rr_arbiter #(.NUM_REQ(N), .CNT_W(2)) u_dut_sat (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_wen(wen),
        .i_req_addr(addr), .i_req_wdata(wdata), .i_req_mask(mask),
        .o_req_gnt(gnt_s), .o_rsp_valid(rsp_vld_s), .o_rsp_rdata(rsp_rdata_s),
        .o_mem_addr(mem_addr_s), .o_mem_ren(mem_ren_s), .o_mem_wen(mem_wen_s),
        .o_mem_wdata(mem_wdata_s), .o_mem_mask(mem_mask_s), .i_mem_rdata(32'h0),
        .o_conflict_cnt(cnt_s)
    );

    // Shared memory model: combinational read, byte-masked write at the clock edge.
    logic [31:0] mem [0:1023];
    assign mem_rdata = mem[mem_addr[11:2]];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) if (mem_wen) mem[mem_addr[11:2]] <= merge(mem[mem_addr[11:2]], mem_wdata, mem_mask);

    typedef struct packed {
        logic [N-1:0] vld;
        logic [31:0]  data;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic set_lane(input int i, input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] m);
        req[i]          = r;
        wen[i]          = w;
        addr[32*i +: 32]  = a;
        wdata[32*i +: 32] = d;
        mask[4*i +: 4]    = m;
    endtask

    task automatic clear_all();
        req = '0; wen = '0; addr = '0; wdata = '0; mask = '0;
    endtask

    // Called just after inputs change (negedge): check grant, queue the expected response.
    task automatic grant_chk(input logic [N-1:0] exp_gnt, input logic [31:0] exp_rd);
        exp_t e;
        #1;
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        if (exp_gnt != '0) begin
            e.vld  = exp_gnt;
            e.data = exp_rd;
            sb_q.push_back(e);
        end
    endtask

    // Cross one rising edge and compare the registered response against the scoreboard.
    task automatic advance();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("rsp_vld", 32'(rsp_vld), 32'(e.vld));
            chk("rsp_data", rsp_rdata, e.data);
        end else begin
            chk("rsp_vld_idle", 32'(rsp_vld), 32'h0);
        end
    endtask

    initial begin
        logic [N-1:0] g;
        rst = 1'b1;
        clear_all();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'hDEADBEEF;
        mem[32'h200 >> 2] = 32'h11223344;
        mem[32'h300 >> 2] = 32'h12345678;
        @(negedge clk);

        // Reset state: requests present but everything held quiet.
        set_lane(0, 1'b1, 1'b1, 32'h104, 32'h5A5A5A5A, 4'hF);
        set_lane(1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        grant_chk(3'b000, 32'h0);
        chk("rst_ren", 32'(mem_ren), 32'h0);
        chk("rst_wen", 32'(mem_wen), 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_mask", 32'(mem_mask), 32'h0);
        advance();
        chk("rst_cnt", 32'(cnt), 32'h0);
        chk("rst_mem_untouched", mem[32'h104 >> 2], 32'h0);

        // Single aligned read by requester 0.
        rst = 1'b0;
        clear_all();
        set_lane(0, 1'b1, 1'b0, 32'h102, 32'h0, 4'hF);
        grant_chk(3'b001, 32'hDEADBEEF);
        chk("rd_addr", mem_addr, 32'h100);
        chk("rd_ren", 32'(mem_ren), 32'h1);
        chk("rd_wen", 32'(mem_wen), 32'h0);
        advance();

        // Write by 1 and read by 2 to the same word, ptr=1: write first, read sees it.
        clear_all();
        set_lane(1, 1'b1, 1'b1, 32'h200, 32'h000000AA, 4'h1);
        set_lane(2, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
        grant_chk(3'b010, 32'h0);
        chk("wr_wen", 32'(mem_wen), 32'h1);
        chk("wr_ren", 32'(mem_ren), 32'h0);
        chk("wr_wdata", mem_wdata, 32'h000000AA);
        chk("wr_mask", 32'(mem_mask), 32'h1);
        advance();
        set_lane(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        grant_chk(3'b100, 32'h112233AA);
        chk("rd2_ren", 32'(mem_ren), 32'h1);
        advance();
        chk("cnt_after_pair", 32'(cnt), 32'h1);

        // Zero mask: granted and answered, memory untouched.
        clear_all();
        set_lane(0, 1'b1, 1'b1, 32'h300, 32'hFFFFFFFF, 4'h0);
        grant_chk(3'b001, 32'h0);
        chk("zm_wen", 32'(mem_wen), 32'h0);
        chk("zm_ren", 32'(mem_ren), 32'h0);
        chk("zm_wdata", mem_wdata, 32'hFFFFFFFF);
        advance();
        chk("zm_mem", mem[32'h300 >> 2], 32'h12345678);

        // Move ptr to 2, then reset during a write request from requester 2.
        clear_all();
        set_lane(1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        grant_chk(3'b010, 32'hDEADBEEF);
        advance();
        clear_all();
        rst = 1'b1;
        set_lane(2, 1'b1, 1'b1, 32'h300, 32'hCAFEF00D, 4'hF);
        grant_chk(3'b000, 32'h0);
        chk("rstw_wen", 32'(mem_wen), 32'h0);
        advance();
        chk("rstw_mem", mem[32'h300 >> 2], 32'h12345678);
        rst = 1'b0;
        set_lane(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        grant_chk(3'b001, 32'hDEADBEEF);
        advance();
        set_lane(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        grant_chk(3'b100, 32'h0);
        advance();
        chk("late_wr_mem", mem[32'h300 >> 2], 32'hCAFEF00D);

        // All three requesting from reset: strict rotation, six conflicts.
        rst = 1'b1;
        clear_all();
        grant_chk(3'b000, 32'h0);
        advance();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_lane(i, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        for (int c = 0; c < 6; c++) begin
            g = 3'b001 << (c % 3);
            grant_chk(g, 32'hDEADBEEF);
            advance();
        end
        chk("rot_cnt", 32'(cnt), 32'd6);
        chk("rot_cnt_sat", 32'(cnt_s), 32'd3);

        // Two requesters held: 2-bit counter climbs then saturates at 3.
        rst = 1'b1;
        clear_all();
        grant_chk(3'b000, 32'h0);
        advance();
        chk("sat_rst", 32'(cnt_s), 32'h0);
        rst = 1'b0;
        set_lane(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        set_lane(1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        for (int c = 0; c < 5; c++) begin
            g = (c % 2 == 0) ? 3'b001 : 3'b010;
            grant_chk(g, 32'hDEADBEEF);
            advance();
            chk("sat_cnt", 32'(cnt_s), (c + 1 > 3) ? 32'd3 : 32'(c + 1));
        end
        chk("wide_cnt", 32'(cnt), 32'd5);

        // Lone requester is granted every cycle.
        clear_all();
        set_lane(2, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
        for (int c = 0; c < 3; c++) begin
            grant_chk(3'b100, 32'h112233AA);
            advance();
        end
        chk("lone_cnt", 32'(cnt), 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_rr_arbiter.md
Name: dmem_rr_arbiter

Overview:
- Shares one data-memory port (aligned address, ren/wen, wdata, byte mask, combinational read) among NUM_REQ requesters, one per core of the three-core build.
- Round-robin grant with a req/gnt handshake; responses are registered and returned the cycle after grant.
- Sits between the harts' dmem interfaces and the single shared dmem; the harts stall while o_req_gnt is low.

Parameters:
- NUM_REQ, 3, number of requesters (2..8); arbitrary, not necessarily a power of two.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- i_clk  in  1  global clock.
- i_rst  in  1  reset. One clock; reset is synchronous and active-high.
- i_req  in  NUM_REQ  per-requester access request; held until granted.
- i_req_wen  in  NUM_REQ  1 = write, 0 = read.
- i_req_addr  in  32*NUM_REQ  byte address; bits[1:0] are ignored, and the address is forwarded aligned.
- i_req_wdata  in  32*NUM_REQ  write data, already lane-shifted.
- i_req_mask  in  4*NUM_REQ  byte-lane mask.
- o_req_gnt  out  NUM_REQ  one-hot grant, combinational; access is accepted at the rising edge where req&gnt.
- o_rsp_valid  out  NUM_REQ  one-hot; high exactly one cycle after that requester's grant.
- o_rsp_rdata  out  32  registered read data; valid only with o_rsp_valid, for a read.
- o_mem_addr  out  32  shared memory address, bits[1:0] = 0.
- o_mem_ren  out  1  shared memory read enable.
- o_mem_wen  out  1  shared memory write enable.
- o_mem_wdata  out  32  shared memory write data.
- o_mem_mask  out  4  shared memory byte mask.
- i_mem_rdata  in  32  shared memory read data, combinational.
- o_conflict_cnt  out  CNT_W  saturating count of cycles with two or more requests.

Behaviour:
- State:
  - ptr: priority base, 0..NUM_REQ-1.
  - rsp_vld_q (NUM_REQ), rsp_data_q (32), conflict_q (CNT_W).
- Reset:
  - ptr=0, rsp_vld_q=0, rsp_data_q=0, conflict_q=0.
  - While i_rst=1: o_req_gnt=0, o_mem_ren=o_mem_wen=0, o_mem_addr/wdata=0, o_mem_mask=0, o_rsp_valid=0.
- Grant selection (combinational):
  - Scan indices ptr, ptr+1, ..., wrapping modulo NUM_REQ with an explicit wrap (no power-of-two masking).
  - The first requester with i_req=1 is the winner k, and o_req_gnt=1<<k.
  - If no request is asserted, o_req_gnt=0.
- Memory drive when a winner k exists:
  - o_mem_addr = {addr_k[31:2],2'b00}.
  - o_mem_ren = ~wen_k & |mask_k.
  - o_mem_wen = wen_k & |mask_k.
  - o_mem_wdata = wdata_k.
  - o_mem_mask = mask_k.
  - ren and wen are never both 1.
  - Zero mask: still granted, still responds, no memory enable asserted.
- Memory drive with no winner: all enables 0; addr, wdata and mask are 0.
- Rising edge with winner k:
  - ptr <= (k==NUM_REQ-1) ? 0 : k+1.
  - rsp_vld_q <= 1<<k.
  - rsp_data_q <= i_mem_rdata for a read with a non-zero mask, else 0.
- Rising edge with no winner: ptr holds; rsp_vld_q <= 0; rsp_data_q holds.
- Outputs: o_rsp_valid=rsp_vld_q and o_rsp_rdata=rsp_data_q.
- Latency: response exactly 1 cycle after grant; a write is visible in memory at that same edge.
- Throughput: one access per cycle. A requester keeping i_req high after its grant may be granted again once the others with priority are served. A lone requester is granted every cycle.
- Fairness: with all NUM_REQ requesting continuously, the grant sequence is a strict rotation. No requester waits more than NUM_REQ-1 cycles.
- Requester contract: addr, wen, wdata and mask must be stable while i_req=1 and o_req_gnt=0. Dropping i_req before grant withdraws the request legally.
- Conflict counter: conflict_q increments on each cycle with popcount(i_req)>=2, and saturates at all-ones.
- Reset mid-operation:
  - A pending response is discarded (o_rsp_valid=0 the cycle after reset is sampled) and ptr returns to 0.
  - A write granted in the same cycle i_rst=1 does not occur, because enables are forced 0.
- Simultaneous events: a response for requester k and a new grant to k in the same cycle are legal and independent.

Decomposition:
- Shared package holds:
  - DMEM_ADDR_W=32, DMEM_DATA_W=32, DMEM_MASK_W=4.
  - Default NUM_REQ=3.
  - Helper function wrap_inc(idx, n).
- One sub-module, rr_pick: combinational rotating-priority picker. Inputs req[NUM_REQ-1:0] and base; outputs one-hot gnt, index and valid. The top level holds all registers and the mux.

Test Plan:
- Reset, then single read: preload mem[0x100]=0xDEADBEEF; req0 read, addr 0x102, mask 0b1111 -> gnt0 same cycle, o_mem_addr=0x100, o_mem_ren=1; next cycle rsp_valid=3'b001, rdata=0xDEADBEEF.
- All three requesting continuously for 6 cycles from reset -> grants 0,1,2,0,1,2; conflict_cnt=6.
- req1 write 0x000000AA mask 0b0001 addr 0x200, and req2 read 0x200 in the same cycle (ptr=1) -> write granted first, read next cycle; rsp to req2 = 0x......AA, with the low byte = 0xAA.
- Zero mask: req0 write, mask 0 -> gnt0=1, o_mem_wen=0, rsp_valid0 next cycle, memory unchanged.
- i_rst asserted in the cycle of a grant to req2 -> no memory write, rsp_valid=0 next cycle, ptr=0 so the next contention between 0 and 2 grants 0.
- CNT_W=2, both of req0 and req1 held for 5 cycles -> conflict_cnt saturates at 3.
